// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt arbiter.
// FSM state encoding, config register addresses and source indices.
package irq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   localparam logic [1:0] CFG_ENABLE = 2'd0;
   localparam logic [1:0] CFG_EDGE   = 2'd1;
   localparam logic [1:0] CFG_CLEAR  = 2'd2;

   localparam int SRC_INT0    = 0;
   localparam int SRC_INT1    = 1;
   localparam int SRC_TIM1    = 2;
   localparam int SRC_TIM2    = 3;
   localparam int SRC_UART_RX = 4;
   localparam int SRC_UART_TX = 5;
   localparam int SRC_GPIO    = 6;
   localparam int SRC_SPARE   = 7;

endpackage

// File: rtl/irq_sync.sv
// Per-line 2-flop synchronizer with a delayed copy for
// rising-edge detection.
module irq_sync (
   input  logic clk,
   input  logic reset,
   input  logic src_i,
   output logic sync_o,
   output logic rise_o
);

   logic meta_q;
   logic sync_q;
   logic dly_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= src_i;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~dly_q;

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: synchronizes sources, keeps pending state and
// hands the lowest enabled pending source to the CPU, one at a time.
module irq_arbiter
   import irq_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] src_in,
   input  logic               cfg_we,
   input  logic [1:0]         cfg_addr,
   input  logic [NUM_SRC-1:0] cfg_wdata,
   output logic [NUM_SRC-1:0] pending_out,
   output logic               irq_req,
   output logic [ID_W-1:0]    irq_id,
   input  logic               irq_ack,
   input  logic               irq_done
);

   logic [NUM_SRC-1:0] sync;
   logic [NUM_SRC-1:0] rise;

   logic [NUM_SRC-1:0] en_q;
   logic [NUM_SRC-1:0] edge_q;
   logic [NUM_SRC-1:0] pend_q;
   logic [NUM_SRC-1:0] pend_d;
   logic [NUM_SRC-1:0] w1c;
   logic [NUM_SRC-1:0] ack_clr;
   logic [NUM_SRC-1:0] act;
   logic [ID_W-1:0]    sel;

   state_e          state_q;
   logic            req_q;
   logic [ID_W-1:0] id_q;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
      irq_sync u_sync (
         .clk    (clk),
         .reset  (reset),
         .src_i  (src_in[g]),
         .sync_o (sync[g]),
         .rise_o (rise[g])
      );
   end

   always_comb begin
      w1c     = '0;
      ack_clr = '0;
      if (cfg_we && cfg_addr == CFG_CLEAR) begin
         w1c = cfg_wdata;
      end
      if (state_q == ST_REQ && irq_ack) begin
         ack_clr = NUM_SRC'(1) << id_q;
      end
      // set beats clear; level sources just mirror the synced line
      pend_d = (edge_q & (rise | (pend_q & ~(w1c | ack_clr))))
             | (~edge_q & sync);
   end

   assign act = pend_q & en_q;

   always_comb begin
      sel = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (act[i]) begin
            sel = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q   <= '0;
         edge_q <= '0;
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
         if (cfg_we && cfg_addr == CFG_ENABLE) begin
            en_q <= cfg_wdata;
         end
         if (cfg_we && cfg_addr == CFG_EDGE) begin
            edge_q <= cfg_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         id_q    <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (|act) begin
                  id_q    <= sel;
                  req_q   <= 1'b1;
                  state_q <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (irq_ack) begin
                  req_q   <= 1'b0;
                  state_q <= ST_SERVICE;
               end
            end
            ST_SERVICE: begin
               if (irq_done) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign pending_out = pend_q;
   assign irq_req     = req_q;
   assign irq_id      = id_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: expected request ids are queued
// as stimulus is applied and checked when irq_req rises.
module tb_irq_arbiter;

   logic       clk;
   logic       reset;
   logic [7:0] src_in;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic [7:0] pending_out;
   logic       irq_req;
   logic [2:0] irq_id;
   logic       irq_ack;
   logic       irq_done;

   int total;
   int bad;
   int exp_q[$];
   logic prev_req;

   irq_arbiter #(.NUM_SRC(8), .ID_W(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .src_in      (src_in),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_wdata   (cfg_wdata),
      .pending_out (pending_out),
      .irq_req     (irq_req),
      .irq_id      (irq_id),
      .irq_ack     (irq_ack),
      .irq_done    (irq_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=0x%0h want=0x%0h", nm, act, exp);
      end
   endtask

   // monitor: every new request must match the head of the queue
   initial prev_req = 1'b0;
   always @(negedge clk) begin
      if (irq_req && !prev_req) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_req got=%0d want=none", irq_id);
         end else begin
            chk("req_id", int'(irq_id), exp_q.pop_front());
         end
      end
      prev_req = irq_req;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      tick(1);
      cfg_we    = 1'b0;
   endtask

   task automatic ack();
      irq_ack = 1'b1;
      tick(1);
      irq_ack = 1'b0;
   endtask

   task automatic done();
      irq_done = 1'b1;
      tick(1);
      irq_done = 1'b0;
   endtask

   task automatic wait_req(input string nm);
      int n;
      n = 0;
      while (!irq_req && n < 12) begin
         tick(1);
         n++;
      end
      chk(nm, int'(irq_req), 1);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      reset     = 1'b0;
      src_in    = '0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_wdata = '0;
      irq_ack   = 1'b0;
      irq_done  = 1'b0;
      tick(3);
      chk("rst_req", int'(irq_req), 0);
      chk("rst_id", int'(irq_id), 0);
      chk("rst_pend", int'(pending_out), 0);
      reset = 1'b1;
      tick(1);

      cfg_write(2'd0, 8'hFF);
      cfg_write(2'd1, 8'hFF);

      // latency: pending at edge 3, request at edge 4
      exp_q.push_back(0);
      src_in = 8'h01;
      tick(3);
      chk("lat_pend3", int'(pending_out), 8'h01);
      chk("lat_req3", int'(irq_req), 0);
      tick(1);
      chk("lat_req4", int'(irq_req), 1);
      ack();
      chk("lat_ack_pend", int'(pending_out), 8'h00);
      chk("lat_ack_req", int'(irq_req), 0);
      src_in = 8'h00;
      done();
      tick(4);
      chk("lat_idle", int'(irq_req), 0);

      // priority: src 2 then src 5
      exp_q.push_back(2);
      exp_q.push_back(5);
      src_in = 8'h24;
      tick(4);
      chk("pri_req", int'(irq_req), 1);
      chk("pri_id2", int'(irq_id), 2);
      src_in = 8'h00;
      ack();
      chk("pri_pend", int'(pending_out), 8'h20);
      done();
      tick(1);
      chk("pri_rereq", int'(irq_req), 1);
      chk("pri_id5", int'(irq_id), 5);
      // ack and done together: only ack counts
      irq_ack  = 1'b1;
      irq_done = 1'b1;
      tick(1);
      irq_ack  = 1'b0;
      irq_done = 1'b0;
      exp_q.push_back(6);
      src_in = 8'h40;
      tick(5);
      chk("nonest_pend", int'(pending_out), 8'h40);
      chk("nonest_req", int'(irq_req), 0);
      src_in = 8'h00;
      done();
      tick(1);
      chk("nonest_rereq", int'(irq_req), 1);
      ack();
      done();

      // set/clear collision on src 0
      cfg_write(2'd0, 8'h00);
      src_in = 8'h01;
      tick(2);
      cfg_write(2'd2, 8'h01);
      chk("coll_pend", int'(pending_out), 8'h01);
      cfg_write(2'd2, 8'h01);
      chk("w1c_pend", int'(pending_out), 8'h00);
      src_in = 8'h00;
      tick(2);

      // masking and no withdraw in REQ
      src_in = 8'h02;
      tick(6);
      chk("mask_pend", int'(pending_out), 8'h02);
      chk("mask_req", int'(irq_req), 0);
      src_in = 8'h00;
      exp_q.push_back(1);
      cfg_write(2'd0, 8'h02);
      tick(1);
      chk("unmask_req", int'(irq_req), 1);
      chk("unmask_id", int'(irq_id), 1);
      cfg_write(2'd0, 8'h00);
      cfg_write(2'd2, 8'h02);
      chk("hold_req", int'(irq_req), 1);
      chk("hold_id", int'(irq_id), 1);
      ack();
      done();
      tick(2);
      chk("mask_end_pend", int'(pending_out), 8'h00);

      // level mode on src 3
      cfg_write(2'd1, 8'hF7);
      cfg_write(2'd0, 8'h08);
      src_in = 8'h08;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(3);
         wait_req("lvl_req");
         chk("lvl_id", int'(irq_id), 3);
         cfg_write(2'd2, 8'h08);
         chk("lvl_w1c_pend", int'(pending_out), 8'h08);
         ack();
         chk("lvl_ack_pend", int'(pending_out), 8'h08);
         if (k == 2) begin
            src_in = 8'h00;
            tick(4);
         end
         done();
      end
      tick(4);
      chk("lvl_low_req", int'(irq_req), 0);
      chk("lvl_low_pend", int'(pending_out), 8'h00);

      // reset abort while in SERVICE
      cfg_write(2'd1, 8'hFF);
      cfg_write(2'd0, 8'hFF);
      exp_q.push_back(4);
      src_in = 8'h10;
      wait_req("rst_pre_req");
      src_in = 8'h00;
      ack();
      src_in = 8'h80;
      tick(4);
      chk("rst_svc_pend", int'(pending_out), 8'h80);
      src_in = 8'h00;
      tick(3);
      reset = 1'b0;
      #1;
      chk("abort_req", int'(irq_req), 0);
      chk("abort_pend", int'(pending_out), 8'h00);
      tick(2);
      reset = 1'b1;
      tick(1);
      cfg_write(2'd0, 8'hFF);
      cfg_write(2'd1, 8'hFF);
      exp_q.push_back(3);
      src_in = 8'h08;
      wait_req("post_rst_req");
      chk("post_rst_id", int'(irq_id), 3);
      src_in = 8'h00;
      ack();
      done();
      tick(4);
      chk("final_req", int'(irq_req), 0);
      chk("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
